// File: rtl/mac_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// mac_accumulator_pkg : shared FSM encoding and default datapath widths
// Rev 1.0
// ============================================================================
package mac_accumulator_pkg;

  localparam int DEF_PROD_W = 10;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_accumulator_if.sv
`default_nettype none
// ============================================================================
// mac_accumulator_if : run control, product stream and result handshakes
// Rev 1.0
// ============================================================================
interface mac_accumulator_if
  import mac_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic                     start;
  logic        [LEN_W-1:0]  len;
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [PROD_W-1:0] prod;
  logic                     sum_valid;
  logic                     sum_ready;
  logic signed [ACC_W-1:0]  sum;
  logic                     overflow;
  logic                     busy;

  modport master (
    output start, len, prod_valid, prod, sum_ready,
    input  prod_ready, sum_valid, sum, overflow, busy
  );

  modport slave (
    input  start, len, prod_valid, prod, sum_ready,
    output prod_ready, sum_valid, sum, overflow, busy
  );

endinterface
`default_nettype wire

// File: rtl/mac_accumulator_sat_detect_adder.sv
`default_nettype none
// ============================================================================
// sat_detect_adder : wrapping signed adder with signed-overflow flag
// Rev 1.0
// ============================================================================
module sat_detect_adder #(
  parameter int W = 16
) (
  input  wire logic signed [W-1:0] a,
  input  wire logic signed [W-1:0] b,
  output logic signed      [W-1:0] sum,
  output logic                     overflow
);

  assign sum      = a + b;
  // Like-signed operands producing an opposite-signed result wrapped.
  assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// mac_accumulator : sums a programmed run of signed products into a result
// Rev 1.0
// ============================================================================
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input wire logic         clk,
  input wire logic         rst_n,
  mac_accumulator_if.slave bus
);

  // len==0 encodes a full 2^LEN_W run, hence the extra count bit.
  localparam logic [LEN_W:0] FULL_RUN = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] ONE      = (LEN_W+1)'(1);

  state_t                   state;
  state_t                   state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  prod_ext;
  logic        [LEN_W:0]    count;
  logic        [ACC_W-1:0]  sum_q;
  logic                     ovf_q;
  logic                     add_ovf;
  logic                     accept;
  logic                     last;
  logic                     take_start;

  assign prod_ext = ACC_W'(bus.prod);

  sat_detect_adder #(
    .W (ACC_W)
  ) u_adder (
    .a        (acc),
    .b        (prod_ext),
    .sum      (acc_nxt),
    .overflow (add_ovf)
  );

  always_comb begin
    state_nxt      = state;
    bus.prod_ready = 1'b0;
    bus.sum_valid  = 1'b0;
    bus.busy       = 1'b0;
    accept         = 1'b0;
    take_start     = 1'b0;
    last           = (count == ONE);
    case (state)
      IDLE: begin
        take_start = bus.start;
        if (bus.start) state_nxt = ACCUM;
      end
      ACCUM: begin
        bus.prod_ready = 1'b1;
        bus.busy       = 1'b1;
        accept         = bus.prod_valid;
        if (bus.prod_valid && last) state_nxt = DONE;
      end
      DONE: begin
        bus.sum_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.sum_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (take_start) begin
      acc   <= '0;
      ovf_q <= 1'b0;
      count <= (bus.len == '0) ? FULL_RUN : {1'b0, bus.len};
    end else if (accept) begin
      acc   <= acc_nxt;
      count <= count - ONE;
      ovf_q <= ovf_q | add_ovf;
      if (last) sum_q <= acc_nxt;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// tb_mac_accumulator : scoreboard bench for mac_accumulator
// Rev 1.0
// ============================================================================
module tb_mac_accumulator;
  import mac_accumulator_pkg::*;

  typedef struct {
    int sum;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_accumulator_if #(.PROD_W(10), .ACC_W(16), .LEN_W(4)) bus ();
  mac_accumulator_if #(.PROD_W(10), .ACC_W(10), .LEN_W(4)) bus_s ();

  mac_accumulator #(.PROD_W(10), .ACC_W(16), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mac_accumulator #(.PROD_W(10), .ACC_W(10), .LEN_W(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   stim[$];
  exp_t q[$];
  exp_t q_s[$];
  exp_t m_e;
  exp_t m_es;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: integer sum checked against the signed range at every step.
  function automatic exp_t model(input int w);
    exp_t e;
    int   a = 0;
    int   hi = (1 << (w - 1)) - 1;
    int   lo = -(1 << (w - 1));
    e.ovf = 0;
    foreach (stim[i]) begin
      a = a + stim[i];
      if (a > hi) begin a = a - (1 << w); e.ovf = 1; end
      else if (a < lo) begin a = a + (1 << w); e.ovf = 1; end
    end
    e.sum = a;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.sum_valid && bus.sum_ready) begin
      if (q.size() == 0) check("unexpected_sum", 1, 0);
      else begin
        m_e = q.pop_front();
        check("sum", int'(bus.sum), m_e.sum);
        check("overflow", int'(bus.overflow), m_e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_s.sum_valid && bus_s.sum_ready) begin
      if (q_s.size() == 0) check("unexpected_sum_s", 1, 0);
      else begin
        m_es = q_s.pop_front();
        check("sum_s", int'(bus_s.sum), m_es.sum);
        check("overflow_s", int'(bus_s.overflow), m_es.ovf);
      end
    end
  end

  task automatic wait_accept();
    int t = 0;
    @(negedge clk);
    while (!bus.prod_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.prod_ready) check("prod_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the bus idle; returns at posedge+1 unless hold.
  task automatic run_main(input int len_v, input int gap, input bit hold);
    bus.len   = 4'(len_v);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    q.push_back(model(16));
    for (int i = 0; i < stim.size(); i++) begin
      bus.prod       = 10'(stim[i]);
      bus.prod_valid = 1'b1;
      wait_accept();
      bus.prod_valid = 1'b0;
      if (gap > 0 && i < stim.size() - 1) begin
        repeat (gap) begin
          @(negedge clk);
          check("gap_ready", int'(bus.prod_ready), 1);
          @(posedge clk);
          #1;
        end
      end
    end
    @(negedge clk);
    check("latency_valid", int'(bus.sum_valid), 1);
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    int   t;
    bus.start = 0; bus.len = 0; bus.prod_valid = 0; bus.prod = 0; bus.sum_ready = 1;
    bus_s.start = 0; bus_s.len = 0; bus_s.prod_valid = 0; bus_s.prod = 0; bus_s.sum_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_prod_ready", int'(bus.prod_ready), 0);
    check("rst_sum_valid", int'(bus.sum_valid), 0);
    check("rst_sum", int'(bus.sum), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // prod_valid in IDLE must not be consumed
    bus.prod_valid = 1'b1; bus.prod = 10'd77;
    @(negedge clk);
    check("idle_ready", int'(bus.prod_ready), 0);
    @(posedge clk);
    #1;
    bus.prod_valid = 1'b0;

    stim = '{5, -3, 256};
    run_main(3, 0, 0);

    stim = '{100, 200};
    run_main(2, 3, 0);

    stim = {};
    for (int i = 0; i < 16; i++) stim.push_back(256);
    run_main(0, 0, 0);
    stim = {};
    for (int i = 0; i < 16; i++) stim.push_back(-512);
    run_main(0, 0, 0);

    // Wrap on the narrow accumulator
    stim = '{511, 1};
    bus_s.len = 4'd2; bus_s.start = 1'b1;
    @(posedge clk);
    #1;
    bus_s.start = 1'b0;
    q_s.push_back(model(10));
    foreach (stim[i]) begin
      bus_s.prod = 10'(stim[i]); bus_s.prod_valid = 1'b1;
      @(negedge clk);
      check("s_ready", int'(bus_s.prod_ready), 1);
      @(posedge clk);
      #1;
    end
    bus_s.prod_valid = 1'b0;
    @(negedge clk);
    check("s_latency", int'(bus_s.sum_valid), 1);
    @(posedge clk);
    #1;

    // Backpressure in DONE with ignored start pulses
    bus.sum_ready = 1'b0;
    stim = '{7, -20};
    run_main(2, 0, 1);
    e = model(16);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.start = (i == 2);
      bus.len   = 4'd1;
      @(negedge clk);
      check("bp_valid", int'(bus.sum_valid), 1);
      check("bp_sum", int'(bus.sum), e.sum);
      check("bp_overflow", int'(bus.overflow), e.ovf);
    end
    @(posedge clk);
    #1;
    bus.sum_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_after_done", int'(bus.busy), 0);
    check("valid_after_done", int'(bus.sum_valid), 0);
    check("sum_hold", int'(bus.sum), e.sum);
    @(posedge clk);
    #1;
    stim = '{42};
    run_main(1, 0, 0);

    // Asynchronous reset mid-run
    bus.len = 4'd4; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.prod = 10'd9; bus.prod_valid = 1'b1;
    wait_accept();
    bus.prod = 10'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_prod_ready", int'(bus.prod_ready), 0);
    check("arst_sum_valid", int'(bus.sum_valid), 0);
    check("arst_sum", int'(bus.sum), 0);
    check("arst_overflow", int'(bus.overflow), 0);
    check("arst_busy", int'(bus.busy), 0);
    bus.prod_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stim = '{-7};
    run_main(1, 0, 0);

    t = 0;
    while ((q.size() != 0 || q_s.size() != 0) && t < 20) begin
      @(posedge clk);
      t++;
    end
    check("drain", q.size() + q_s.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
